booth_datapath: RTL and testbench
=================================

Name: booth_datapath

Overview:
- Arithmetic datapath of the radix-2 Booth multiplier. It sits directly downstream of the multiplier control FSM and executes that FSM's mult_control_t commands.
- It holds the multiplicand, the accumulator (HQ), the multiplier/low-product register (LQ) and the Q_1 bit.
- It returns Q_0/Q_1 and the iteration-done flag Z to the FSM, and presents the signed 2N-bit product with a valid flag.

Parameters:
N, 8, operand width in bits (two's-complement signed); N >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
A_in  input  N  multiplicand, signed
B_in  input  N  multiplier, signed
mult_control  input  mult_control_t  fields load_A, load_B, load_add, shift_HQ_LQ_Q_1, add_sub (1 = add, 0 = subtract)
Q_0  output  1  LQ[0]
Q_1  output  1  Booth extra bit register
Z  output  1  high when shift counter == 0
product  output  2N  {HQ[N-1:0], LQ}, signed result
product_valid  output  1  product holds a completed result
protocol_err  output  1  one-cycle pulse on an illegal command combination

Behaviour:
- Registers:
  - M (N bits).
  - HQ (N+1 bits, sign-extended guard bit so that subtracting -2^(N-1) cannot overflow).
  - LQ (N bits).
  - q1 (1 bit).
  - cnt (ceil(log2(N+1)) bits).
  - pv (1 bit).
- Reset (rst = 0, asynchronous): M = 0, HQ = 0, LQ = 0, q1 = 0, cnt = 0, pv = 0, protocol_err = 0. Consequently Q_0 = 0, Q_1 = 0, Z = 1, product = 0, product_valid = 0.
- Reset asserted mid-multiplication aborts it immediately; no partial result is retained.
- load_A: M <= A_in on the next edge.
- load_B:
  - LQ <= B_in, HQ <= 0, q1 <= 0, cnt <= N, pv <= 0.
  - load_A and load_B in the same cycle are legal and both take effect.
- load_add:
  - HQ <= HQ + sext(M) when add_sub = 1; HQ <= HQ - sext(M) when add_sub = 0.
  - Arithmetic is N+1 bits, wrap-around modulo 2^(N+1); no saturation.
- shift_HQ_LQ_Q_1:
  - Arithmetic right shift of the 2N+2-bit vector {HQ, LQ, q1}: HQ[N] is replicated, HQ[0] enters LQ[N-1], LQ[0] enters q1.
  - cnt <= cnt - 1.
  - If cnt == 1 before the shift, pv <= 1 on the same edge.
- Shift when cnt == 0: ignored (no register change), and protocol_err pulses.
- Priority and conflicts, per cycle:
  - load_B overrides load_add and shift for HQ/LQ/q1/cnt.
  - load_add together with shift: the add executes, the shift is dropped, and protocol_err pulses for one cycle.
  - protocol_err is registered; it is high the cycle after the offending command and low otherwise.
- Outputs Q_0, Q_1, Z, product and product_valid are driven combinationally from the registers, so they reflect updated values one cycle after the command (latency 1).
- The FSM samples Q_0/Q_1 in the cycle after load_B or a shift.
- Z = 1 exactly when cnt == 0. Z is high after reset and after N shifts.
- product_valid stays high, and the product stays stable, until the next load_B or reset. Further load_A or load_add commands while pv = 1 still modify M/HQ; pv is not cleared by them.
- No command asserted: all registers hold.
- Full sequence for one multiply:
  - Pass 1: load_A + load_B (1 cycle).
  - Pass 2: per bit, optional load_add then shift.
  - Pass 3: after N shifts, Z = 1 and product_valid = 1.
- Booth decision (performed by the FSM, not here): {Q_0, Q_1} = 10 means subtract, 01 means add, 00/11 means shift only.

Test Plan:
- Reset: hold rst = 0 with random inputs and control asserted. Response: product = 0, Z = 1, product_valid = 0, protocol_err = 0. Release, idle 3 cycles, all values unchanged.
- Basic multiply: A = 7, B = 5, drive the correct Booth command sequence for N = 8. Response: after 8th shift product = 16'h0023, Z = 1, product_valid = 1 on that edge's output; Q_0/Q_1 correct each step vs model.
- Signed mixed: A = 3, B = -2 (8'hFE). Response: product = 16'hFFFA.
- Guard bit / extreme: A = -128, B = -128. Response: product = 16'h4000, no wrap error. A = -128, B = 127. Response: product = 16'hC080.
- Illegal commands: shift asserted while Z = 1. Response: registers unchanged, protocol_err high exactly one cycle. load_add + shift together: only the add applied, cnt unchanged, protocol_err pulses.
- Mid-operation: load_B after 4 shifts. Response: HQ = 0, cnt = 8, product_valid = 0, restart gives correct result. Async rst low mid-cycle. Response: outputs clear before next clk edge.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared command type between the Booth multiplier control FSM and its datapath.
package booth_pkg;

    // One command word per cycle from the FSM; add_sub selects add (1) or subtract (0).
    typedef struct packed {
        logic load_A;
        logic load_B;
        logic load_add;
        logic shift_HQ_LQ_Q_1;
        logic add_sub;
    } mult_control_t;

endpackage

// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: multiplicand M, accumulator HQ (with guard
// bit), multiplier/low-product LQ, Booth extra bit q1 and a shift counter.
// Executes one mult_control_t command per cycle and reports Q_0/Q_1/Z back to
// the control FSM. The signed 2N-bit product is {HQ[N-1:0], LQ}.
module booth_datapath
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      A_in,
    input  logic [N-1:0]      B_in,
    input  mult_control_t     mult_control,
    output logic              Q_0,
    output logic              Q_1,
    output logic              Z,
    output logic [2*N-1:0]    product,
    output logic              product_valid,
    output logic              protocol_err
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  m_q,    m_d;
    logic [N:0]    hq_q,   hq_d;
    logic [N-1:0]  lq_q,   lq_d;
    logic          q1_q,   q1_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          pv_q,   pv_d;
    logic          perr_q, perr_d;

    // Sign-extended multiplicand; the extra bit keeps HQ - (-2^(N-1)) in range.
    logic [N:0] m_ext;
    assign m_ext = {m_q[N-1], m_q};

    // Next-state decode: load_B wins over add/shift, add wins over shift.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        m_d    = m_q;
        hq_d   = hq_q;
        lq_d   = lq_q;
        q1_d   = q1_q;
        cnt_d  = cnt_q;
        pv_d   = pv_q;
        perr_d = 1'b0;

        if (mult_control.load_A) begin
            m_d = A_in;
        end

        if (mult_control.load_B) begin
            hq_d  = '0;
            lq_d  = B_in;
            q1_d  = 1'b0;
            cnt_d = CW'(N);
            pv_d  = 1'b0;
        end else if (mult_control.load_add) begin
            hq_d = mult_control.add_sub ? (hq_q + m_ext) : (hq_q - m_ext);
            // Add and shift together is illegal: the shift is dropped.
            if (mult_control.shift_HQ_LQ_Q_1) begin
                perr_d = 1'b1;
            end
        end else if (mult_control.shift_HQ_LQ_Q_1) begin
            if (cnt_q == '0) begin
                // All N shifts already done: ignore and flag.
                perr_d = 1'b1;
            end else begin
                {hq_d, lq_d, q1_d} = {hq_q[N], hq_q, lq_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    pv_d = 1'b1;
                end
            end
        end
    end

    // State registers; asynchronous active-low reset aborts any multiplication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= '0;
            hq_q   <= '0;
            lq_q   <= '0;
            q1_q   <= 1'b0;
            cnt_q  <= '0;
            pv_q   <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            m_q    <= m_d;
            hq_q   <= hq_d;
            lq_q   <= lq_d;
            q1_q   <= q1_d;
            cnt_q  <= cnt_d;
            pv_q   <= pv_d;
            perr_q <= perr_d;
        end
    end

    assign Q_0           = lq_q[0];
    assign Q_1           = q1_q;
    assign Z             = (cnt_q == '0);
    assign product       = {hq_q[N-1:0], lq_q};
    assign product_valid = pv_q;
    assign protocol_err  = perr_q;

endmodule

// File: tb/tb_booth_datapath.sv
// Bench for booth_datapath (N = 8). The stimulus process plays the role of the
// Booth control FSM, deciding add/subtract from the multiplier bits it loaded,
// and pushes each hand-computed product into a queue; a separate monitor pops
// and compares whenever product_valid rises.
module tb_booth_datapath;
    import booth_pkg::*;

    localparam int N = 8;

    logic              clk;
    logic              rst;
    logic [N-1:0]      A_in;
    logic [N-1:0]      B_in;
    mult_control_t     ctl;
    logic              Q_0;
    logic              Q_1;
    logic              Z;
    logic [2*N-1:0]    product;
    logic              product_valid;
    logic              protocol_err;

    int checks   = 0;
    int failures = 0;
    logic [2*N-1:0] exp_q[$];

    booth_datapath #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .A_in         (A_in),
        .B_in         (B_in),
        .mult_control (ctl),
        .Q_0          (Q_0),
        .Q_1          (Q_1),
        .Z            (Z),
        .product      (product),
        .product_valid(product_valid),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mult_control_t mk(input logic la, input logic lb, input logic ladd,
                                         input logic sh, input logic as);
        mult_control_t c;
        c.load_A           = la;
        c.load_B           = lb;
        c.load_add         = ladd;
        c.shift_HQ_LQ_Q_1  = sh;
        c.add_sub          = as;
        return c;
    endfunction

    // Called at a negedge; applies one command for one clock and returns at the next negedge.
    task automatic issue(input mult_control_t c);
        ctl = c;
        @(posedge clk);
        @(negedge clk);
        ctl = '0;
    endtask

    task automatic load(input logic [N-1:0] a, input logic [N-1:0] b, input logic with_a);
        A_in = a;
        B_in = b;
        issue(mk(with_a, 1'b1, 1'b0, 1'b0, 1'b0));
        check("load_q0", Q_0, b[0]);
        check("load_q1", Q_1, 1'b0);
        check("load_z", Z, 1'b0);
        check("load_pv", product_valid, 1'b0);
        check("load_hq_lq", product, {8'h00, b});
    endtask

    // One Booth iteration i using the loaded multiplier bits as the decision model.
    task automatic step(input logic [N-1:0] b, input int i);
        logic cur;
        logic prev;
        cur  = b[i];
        prev = (i == 0) ? 1'b0 : b[i-1];
        check($sformatf("q0_step%0d", i), Q_0, cur);
        check($sformatf("q1_step%0d", i), Q_1, prev);
        if ({cur, prev} == 2'b10) issue(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        else if ({cur, prev} == 2'b01) issue(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        issue(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        check($sformatf("z_step%0d", i), Z, (i == N - 1));
        check($sformatf("pv_step%0d", i), product_valid, (i == N - 1));
        check($sformatf("perr_step%0d", i), protocol_err, 1'b0);
    endtask

    task automatic multiply(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp);
        exp_q.push_back(exp);
        load(a, b, 1'b1);
        for (int i = 0; i < N; i++) step(b, i);
    endtask

    // Monitor: every rising product_valid must match the oldest expected product.
    initial begin : monitor
        logic pv_prev;
        logic [2*N-1:0] e;
        pv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (product_valid && !pv_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", product, e);
                end
            end
            pv_prev = product_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst  = 1'b0;
        A_in = '0;
        B_in = '0;
        ctl  = '0;

        // Reset held with random inputs and commands.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A_in = N'($urandom);
            B_in = N'($urandom);
            ctl  = mult_control_t'(5'($urandom));
        end
        #1;
        check("rst_product", product, 16'h0000);
        check("rst_z", Z, 1'b1);
        check("rst_pv", product_valid, 1'b0);
        check("rst_perr", protocol_err, 1'b0);
        check("rst_q0", Q_0, 1'b0);
        check("rst_q1", Q_1, 1'b0);
        @(negedge clk);
        ctl = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_product", product, 16'h0000);
        check("idle_z", Z, 1'b1);
        check("idle_pv", product_valid, 1'b0);
        check("idle_perr", protocol_err, 1'b0);

        // Directed products.
        multiply(8'd7,   8'd5,   16'h0023);
        multiply(8'd3,   8'hFE,  16'hFFFA);
        multiply(8'h80,  8'h80,  16'h4000);
        multiply(8'h80,  8'h7F,  16'hC080);
        multiply(8'd5,   8'hF9,  16'hFFDD);

        // Result holds; a shift with Z = 1 is ignored and flagged for one cycle.
        issue('0);
        check("hold_product", product, 16'hFFDD);
        check("hold_pv", product_valid, 1'b1);
        issue(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        check("zshift_perr", protocol_err, 1'b1);
        check("zshift_product", product, 16'hFFDD);
        check("zshift_z", Z, 1'b1);
        check("zshift_pv", product_valid, 1'b1);
        issue('0);
        check("zshift_perr_clear", protocol_err, 1'b0);

        // load_add together with shift: add only, counter untouched.
        load(8'd3, 8'd5, 1'b1);
        issue(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
        check("addsh_perr", protocol_err, 1'b1);
        check("addsh_product", product, 16'h0305);
        check("addsh_q1", Q_1, 1'b0);
        check("addsh_z", Z, 1'b0);
        issue('0);
        check("addsh_perr_clear", protocol_err, 1'b0);

        // load_B after 4 iterations restarts cleanly with the held multiplicand.
        load(8'd7, 8'd5, 1'b1);
        for (int i = 0; i < 4; i++) step(8'd5, i);
        exp_q.push_back(16'hFFEB);
        load(8'd7, 8'hFD, 1'b0);
        for (int i = 0; i < N; i++) step(8'hFD, i);

        // Asynchronous reset mid-multiplication clears outputs before the next edge.
        load(8'd7, 8'd5, 1'b1);
        for (int i = 0; i < 3; i++) step(8'd5, i);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_product", product, 16'h0000);
        check("arst_z", Z, 1'b1);
        check("arst_pv", product_valid, 1'b0);
        check("arst_q0", Q_0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        multiply(8'd7, 8'd5, 16'h0023);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
